// File: rtl/rv32m_pkg.sv
// Shared RV32M types: decoded op bundle, mul/div FSM states and result constants.
package rv32m_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } rv32m_op_e;

   typedef struct packed {
      logic      select;
      rv32m_op_e op;
   } rv32m_decode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL_EXEC,
      ST_DIV_ITER,
      ST_DIV_FIX,
      ST_DONE
   } rv32m_muldiv_state_t;

   localparam logic [31:0] RV32M_DIV_BY_ZERO_Q = 32'hFFFFFFFF;
   localparam logic [31:0] RV32M_INT_MIN       = 32'h80000000;

   function automatic logic [31:0] rv32m_abs(input logic [31:0] v,
                                             input logic        sgn);
      return (sgn && v[31]) ? 32'(-v) : v;
   endfunction

endpackage

// File: rtl/rv32m_div_core.sv
// Unsigned restoring divider; retires DIV_BITS_PER_CYCLE quotient bits per step.
module rv32m_div_core #(
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic        clk_i,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q;
   logic [32:0] part;

   // Dividend bits shift out of quo_q while quotient bits shift in.
   always_comb begin
      quo_d = quo_q;
      rem_d = rem_q;
      part  = '0;
      for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
         part  = {rem_d, quo_d[31]};
         quo_d = {quo_d[30:0], 1'b0};
         if (part >= {1'b0, dvs_q}) begin
            part     = part - {1'b0, dvs_q};
            quo_d[0] = 1'b1;
         end
         rem_d = part[31:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M execute-side multiply/divide unit with fixed-latency multiply and iterative divide.
// Define RV32M_DIVREM_FUSE_EN to reuse the last divide's quotient/remainder on a matching op.
module rv32m_muldiv_unit
   import rv32m_pkg::*;
#(
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  rv32m_decode_t decode_in,
   input  logic          start,
   input  logic          flush,
   input  logic [31:0]   rs1_data,
   input  logic [31:0]   rs2_data,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [31:0]   result
);

   localparam int         ITER = 32 / DIV_BITS_PER_CYCLE;
   localparam logic [5:0] LAST = 6'(ITER - 1);

   rv32m_muldiv_state_t state_q, state_d;
   rv32m_op_e           op_q, op_d;
   logic [31:0]         a_q, a_d, b_q, b_d;
   logic [31:0]         result_q, result_d;
   logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [5:0]          cnt_q, cnt_d;

   logic [2:0]  in_op;
   logic        accept, in_div, in_sgn, in_rem;
   logic        div_zero, div_ovf, special, hit, div_load;
   logic [31:0] special_res, hit_res;
   logic [31:0] quo, rem, quo_fix, rem_fix, mul_res;
   logic        a_ext, b_ext, rem_q_op;
   logic signed [63:0] mul_a, mul_b, prod;

   assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy   = (state_q == ST_MUL_EXEC) || (state_q == ST_DIV_ITER)
                || (state_q == ST_DIV_FIX);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign accept = ready && start && decode_in.select && !flush;

   assign in_op    = decode_in.op;
   assign in_div   = in_op[2];
   assign in_sgn   = !in_op[0];
   assign in_rem   = in_op[1];
   assign div_zero = (rs2_data == '0);
   assign div_ovf  = in_sgn && (rs1_data == RV32M_INT_MIN)
                  && (rs2_data == '1);
   assign special  = in_div && (div_zero || div_ovf);
   assign special_res = div_zero
      ? (in_rem ? rs1_data : RV32M_DIV_BY_ZERO_Q)
      : (in_rem ? 32'h0 : RV32M_INT_MIN);

   // 33-bit extended operands, widened further so the low 64 product bits are exact.
   assign a_ext   = (op_q != OP_MULHU) && a_q[31];
   assign b_ext   = ((op_q == OP_MUL) || (op_q == OP_MULH)) && b_q[31];
   assign mul_a   = {{32{a_ext}}, a_q};
   assign mul_b   = {{32{b_ext}}, b_q};
   assign prod    = mul_a * mul_b;
   assign mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

   assign div_load = accept && in_div && !special && !hit;

   rv32m_div_core #(
      .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
   ) u_div (
      .clk_i      (CLK),
      .load_i     (div_load),
      .step_i     (state_q == ST_DIV_ITER),
      .dividend_i (rv32m_abs(rs1_data, in_sgn)),
      .divisor_i  (rv32m_abs(rs2_data, in_sgn)),
      .quotient_o (quo),
      .remainder_o(rem)
   );

   assign quo_fix  = q_neg_q ? 32'(-quo) : quo;
   assign rem_fix  = r_neg_q ? 32'(-rem) : rem;
   assign rem_q_op = (op_q == OP_REM) || (op_q == OP_REMU);

`ifdef RV32M_DIVREM_FUSE_EN
   logic        c_valid_q, c_sgn_q;
   logic [31:0] c_a_q, c_b_q, c_quo_q, c_rem_q;

   assign hit = in_div && c_valid_q && (c_sgn_q == in_sgn)
             && (c_a_q == rs1_data) && (c_b_q == rs2_data);
   assign hit_res = in_rem ? c_rem_q : c_quo_q;

   always_ff @(posedge CLK) begin
      if (RST || flush || (accept && special)) begin
         c_valid_q <= 1'b0;
      end else if (state_q == ST_DIV_FIX) begin
         c_valid_q <= 1'b1;
         c_sgn_q   <= (op_q == OP_DIV) || (op_q == OP_REM);
         c_a_q     <= a_q;
         c_b_q     <= b_q;
         c_quo_q   <= quo_fix;
         c_rem_q   <= rem_fix;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_res = '0;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      cnt_d    = cnt_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_MUL_EXEC: begin
               result_d = mul_res;
               state_d  = ST_DONE;
            end
            ST_DIV_ITER: begin
               cnt_d = cnt_q - 6'd1;
               if (cnt_q == '0) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
               result_d = rem_q_op ? rem_fix : quo_fix;
               state_d  = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
               if (accept) begin
                  op_d    = decode_in.op;
                  a_d     = rs1_data;
                  b_d     = rs2_data;
                  q_neg_d = in_sgn && (rs1_data[31] ^ rs2_data[31]);
                  r_neg_d = in_sgn && rs1_data[31];
                  cnt_d   = LAST;
                  if (special) begin
                     result_d = special_res;
                     state_d  = ST_DONE;
                  end else if (hit) begin
                     result_d = hit_res;
                     state_d  = ST_DONE;
                  end else if (in_div) begin
                     state_d = ST_DIV_ITER;
                  end else begin
                     state_d = ST_MUL_EXEC;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed cases plus randomized ops
// against an arithmetic reference model of results and latency.
`timescale 1ns/1ps
module tb_rv32m_muldiv_unit;
   import rv32m_pkg::*;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   rv32m_decode_t decode_in = '0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [31:0]   rs1_data = '0;
   logic [31:0]   rs2_data = '0;
   logic          ready, busy, done;
   logic [31:0]   result;

   rv32m_muldiv_unit dut (
      .CLK      (CLK),
      .RST      (RST),
      .decode_in(decode_in),
      .start    (start),
      .flush    (flush),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        me;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res = '0;

   bit          c_valid = 1'b0;
   bit          c_sgn = 1'b0;
   logic [31:0] c_a = '0;
   logic [31:0] c_b = '0;

   string op_name [8] = '{"MUL", "MULH", "MULHSU", "MULHU",
                          "DIV", "DIVU", "REM", "REMU"};

   function automatic logic [31:0] ref_res(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint    sa = longint'(signed'(a));
      longint    sb_ = longint'(signed'(b));
      longint    ua = longint'({32'h0, a});
      longint    ub = longint'({32'h0, b});
      logic [63:0] p;
      bit        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (op)
         3'd0: p = 64'(sa * sb_);
         3'd1: p = 64'(sa * sb_);
         3'd2: p = 64'(sa * ub);
         3'd3: p = 64'(ua * ub);
         3'd4: p = (b == 0) ? 64'hFFFFFFFF : ovf ? 64'h80000000
                                           : 64'(sa / sb_);
         3'd5: p = (b == 0) ? 64'hFFFFFFFF : 64'(ua / ub);
         3'd6: p = (b == 0) ? ua : ovf ? 64'h0 : 64'(sa % sb_);
         default: p = (b == 0) ? ua : 64'(ua % ub);
      endcase
      if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[63:32];
      return p[31:0];
   endfunction

   function automatic int ref_lat(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      bit sgn = !op[0];
      if (!op[2]) return 2;
      if (b == 0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) begin
         c_valid = 1'b0;
         return 1;
      end
`ifdef RV32M_DIVREM_FUSE_EN
      if (c_valid && c_a == a && c_b == b && c_sgn == sgn) return 1;
`endif
      c_valid = 1'b1;
      c_a     = a;
      c_b     = b;
      c_sgn   = sgn;
      return 34;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding op.
   always @(negedge CLK) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: result %h at cycle %0d, none pending",
                     result, cyc);
         end else begin
            me = sb.pop_front();
            chk({me.name, "_result"}, result, me.res);
            chk({me.name, "_done_cycle"}, 32'(cyc), 32'(me.cyc));
            last_res = me.res;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fixed,
                        input logic [31:0] fres);
      int   n = 0;
      exp_t e;
      @(negedge CLK);
      while (!ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready %b expected 1", ready);
         return;
      end
      decode_in = '{select: 1'b1, op: rv32m_op_e'(op)};
      rs1_data  = a;
      rs2_data  = b;
      start     = 1'b1;
      e.res     = fixed ? fres : ref_res(op, a, b);
      e.cyc     = cyc + ref_lat(op, a, b);
      e.name    = op_name[op];
      sb.push_back(e);
      @(posedge CLK);
      #1;
      start     = 1'b0;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      decode_in = rv32m_decode_t'(4'($urandom));
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (sb.size() != 0 || busy) begin
         errors++;
         $display("FAIL drain_timeout: %0d ops pending, expected 0", sb.size());
         sb.delete();
      end
      @(negedge CLK);
   endtask

   task automatic kill_div(input bit use_rst);
      issue(3'd4, 32'd5000, 32'd3, 1'b0, '0);
      repeat (10) @(negedge CLK);
      void'(sb.pop_back());
      c_valid = 1'b0;
      if (use_rst) RST = 1'b1;
      else flush = 1'b1;
      start = 1'b1;
      @(posedge CLK);
      #1;
      RST   = 1'b0;
      flush = 1'b0;
      start = 1'b0;
      if (use_rst) last_res = '0;
      @(negedge CLK);
      chk(use_rst ? "rst_busy" : "flush_busy", 32'(busy), 32'd0);
      chk(use_rst ? "rst_ready" : "flush_ready", 32'(ready), 32'd1);
      chk(use_rst ? "rst_result" : "flush_result", result, last_res);
      repeat (40) @(negedge CLK);
      issue(3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
      @(negedge CLK);
      chk("result_before_mul_done", result, last_res);
      drain();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(5))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      logic [2:0]  op;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_result", result, 32'h0);
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);

      issue(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB);
      @(negedge CLK);
      chk("mul_busy_c1", 32'(busy), 32'd1);
      chk("mul_done_c1", 32'(done), 32'd0);
      @(negedge CLK);
      chk("mul_busy_c2", 32'(busy), 32'd0);
      drain();

      issue(3'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000);
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);
      issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE);
      issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD);
      issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF);
      issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
      issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2);
      issue(3'd5, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF);
      issue(3'd6, 32'd5, 32'd0, 1'b1, 32'd5);
      issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000);
      issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0);
      drain();

      kill_div(1'b0);
      kill_div(1'b1);

      issue(3'd4, 32'd1000, 32'd3, 1'b1, 32'd333);
      repeat (5) @(negedge CLK);
      decode_in = '{select: 1'b1, op: OP_MUL};
      rs1_data  = 32'd9;
      rs2_data  = 32'd9;
      start     = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("busy_start_result", result, last_res);
      chk("busy_start_busy", 32'(busy), 32'd1);
      drain();

      issue(3'd4, 32'd100, 32'd7, 1'b1, 32'd14);
      issue(3'd6, 32'd100, 32'd7, 1'b1, 32'd2);
      drain();
      issue(3'd4, 32'd100, 32'd7, 1'b1, 32'd14);
      drain();
      flush = 1'b1;
      c_valid = 1'b0;
      @(negedge CLK);
      flush = 1'b0;
      issue(3'd6, 32'd100, 32'd7, 1'b1, 32'd2);
      drain();

      a = pick();
      b = pick();
      for (int i = 0; i < 150; i++) begin
         op = 3'($urandom_range(7));
         if ($urandom_range(3) != 0) begin
            a = pick();
            b = pick();
         end
         issue(op, a, b, 1'b0, '0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
